vga_timing_gen: RTL and testbench

- Upstream raster timing stage for the game display: produces the pixel coordinates, active-video flag and sync pulses that the sprite and colour logic consume.
- Runs on the 50 MHz board clock and derives the pixel rate internally with a clock enable, so no divided clock is created in fabric.
- Also emits a once-per-frame tick so game-object motion (ship, bullet, enemy) can advance on frame boundaries instead of using a free-running divider.

---
 rtl/vga_pkg.sv | 43 ++++
 rtl/vga_timing_gen_if.sv | 29 ++
 rtl/vga_axis_counter.sv | 78 +++++++
 rtl/vga_timing_gen.sv | 146 ++++++++++++++
 tb/tb_vga_timing_gen.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Shared definitions for the VGA raster timing slice: 640x480@60 timing
// defaults, coordinate type, colour struct and small helper functions.
package vga_pkg;

    localparam int COORD_W = 10;

    // 640x480@60 defaults (25 MHz pixel rate from a 50 MHz clock).
    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;
    localparam int PIX_DIV_DEF  = 2;
    localparam bit SYNC_POL_DEF = 1'b0;

    typedef logic [COORD_W-1:0] coord_t;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb_t;

    // True when lo <= c < hi; done in int so a window ending at 1024 works.
    function automatic logic in_span(input coord_t c, input int lo, input int hi);
        return (int'(c) >= lo) && (int'(c) < hi);
    endfunction

    // Colour of the vertical bar containing column x (bar index bits -> R,G,B).
    function automatic rgb_t bar_colour(input coord_t x, input int bar_w);
        int   idx;
        rgb_t c;
        idx = int'(x) / bar_w;
        c.r = {4{idx[2]}};
        c.g = {4{idx[1]}};
        c.b = {4{idx[0]}};
        return c;
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle: coordinates, active flag, syncs, ticks and test colours.
// The timing generator drives it through the master modport; sprite/colour
// logic consumes it through the slave modport.
interface vga_timing_gen_if;
    import vga_pkg::*;

    logic       oPixEn;
    coord_t     oX;
    coord_t     oY;
    logic       oActive;
    logic       oVGA_HS;
    logic       oVGA_VS;
    logic       oLineTick;
    logic       oFrameTick;
    logic [3:0] oTestR;
    logic [3:0] oTestG;
    logic [3:0] oTestB;

    modport master (
        output oPixEn, oX, oY, oActive, oVGA_HS, oVGA_VS,
        output oLineTick, oFrameTick, oTestR, oTestG, oTestB
    );

    modport slave (
        input oPixEn, oX, oY, oActive, oVGA_HS, oVGA_VS,
        input oLineTick, oFrameTick, oTestR, oTestG, oTestB
    );

endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: counts 0..ACTIVE+FP+SYNC+BP-1 on enable, flags the
// terminal step (wrap), and keeps registered active/sync flags for the
// count it holds. The flags are reloaded on every refresh strobe so an axis
// whose count only moves occasionally still leaves reset with valid flags.
// With VGA_TIMING_TEST_PATTERN_EN the look-ahead count is exported so the
// parent can register data aligned with the counter.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int ACTIVE = H_ACTIVE_DEF,
    parameter int FP     = H_FP_DEF,
    parameter int SYNC   = H_SYNC_DEF,
    parameter int BP     = H_BP_DEF,
    parameter bit POL    = SYNC_POL_DEF
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   enable,
    input  logic   refresh,
    output coord_t count,
`ifdef VGA_TIMING_TEST_PATTERN_EN
    output coord_t count_next,
`endif
    output logic   wrap,
    output logic   active,
    output logic   sync
);

    localparam int TOTAL      = ACTIVE + FP + SYNC + BP;
    localparam int SYNC_START = ACTIVE + FP;
    localparam int SYNC_END   = ACTIVE + FP + SYNC;
    localparam coord_t LAST   = coord_t'(TOTAL - 1);

    if (TOTAL > (1 << COORD_W)) begin : g_total_check
        $error("vga_axis_counter: total %0d does not fit a %0d-bit counter", TOTAL, COORD_W);
    end

`ifndef VGA_TIMING_TEST_PATTERN_EN
    coord_t count_next;
`endif

    coord_t count_reg;
    logic   active_reg;
    logic   sync_reg;

    assign wrap = enable && (count_reg == LAST);

    // Look-ahead count: what the counter will hold after this edge.
    always_comb begin
        count_next = count_reg;
        if (enable) begin
            count_next = wrap ? '0 : count_reg + 1'b1;
        end
    end

    // Count register plus window flags computed from the look-ahead count,
    // so flags and count change on the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_reg  <= '0;
            active_reg <= 1'b0;
            sync_reg   <= ~POL;
        end else begin
            if (enable) begin
                count_reg <= count_next;
            end
            if (refresh) begin
                active_reg <= in_span(count_next, 0, ACTIVE);
                sync_reg   <= in_span(count_next, SYNC_START, SYNC_END) ? POL : ~POL;
            end
        end
    end

    assign count  = count_reg;
    assign active = active_reg;
    assign sync   = sync_reg;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator. Derives the pixel slot from the system clock
// with a clock-enable divider, runs horizontal/vertical axis counters and
// emits aligned coordinates, active flag, syncs, line/frame ticks.
// Optional colour-bar test pattern: define VGA_TIMING_TEST_PATTERN_EN.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF,
    parameter int PIX_DIV  = PIX_DIV_DEF,
    parameter bit SYNC_POL = SYNC_POL_DEF
) (
    input  logic             iClock,
    input  logic             iReset_n,
    vga_timing_gen_if.master vga
);

    localparam int DIV_W = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

    if (PIX_DIV < 1) begin : g_div_check
        $error("vga_timing_gen: PIX_DIV must be at least 1 (got %0d)", PIX_DIV);
    end

    logic [DIV_W-1:0] div_reg;
    logic             pe;
    logic             pix_en_reg;
    logic             line_tick_reg;
    logic             frame_tick_reg;

    coord_t h_count;
    coord_t v_count;
    logic   h_wrap;
    logic   v_wrap;
    logic   h_active;
    logic   v_active;
    logic   h_sync;
    logic   v_sync;
    logic   v_enable;

    assign pe       = (div_reg == DIV_W'(PIX_DIV - 1));
    assign v_enable = pe & h_wrap;

`ifdef VGA_TIMING_TEST_PATTERN_EN
    coord_t h_next;
    coord_t v_next;
`endif

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .POL    (SYNC_POL)
    ) h_counter (
        .clk        (iClock),
        .rst_n      (iReset_n),
        .enable     (pe),
        .refresh    (pe),
        .count      (h_count),
`ifdef VGA_TIMING_TEST_PATTERN_EN
        .count_next (h_next),
`endif
        .wrap       (h_wrap),
        .active     (h_active),
        .sync       (h_sync)
    );

    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .POL    (SYNC_POL)
    ) v_counter (
        .clk        (iClock),
        .rst_n      (iReset_n),
        .enable     (v_enable),
        .refresh    (pe),
        .count      (v_count),
`ifdef VGA_TIMING_TEST_PATTERN_EN
        .count_next (v_next),
`endif
        .wrap       (v_wrap),
        .active     (v_active),
        .sync       (v_sync)
    );

    // Pixel-rate divider and the pixel/line/frame strobes, all delayed one
    // cycle so they coincide with the coordinate they belong to.
    always_ff @(posedge iClock) begin
        if (!iReset_n) begin
            div_reg        <= '0;
            pix_en_reg     <= 1'b0;
            line_tick_reg  <= 1'b0;
            frame_tick_reg <= 1'b0;
        end else begin
            div_reg        <= pe ? '0 : div_reg + 1'b1;
            pix_en_reg     <= pe;
            line_tick_reg  <= h_wrap;
            frame_tick_reg <= v_wrap;
        end
    end

    assign vga.oPixEn     = pix_en_reg;
    assign vga.oX         = h_count;
    assign vga.oY         = v_count;
    // Both flags are flops reloaded on the same pixel edge.
    assign vga.oActive    = h_active & v_active;
    assign vga.oVGA_HS    = h_sync;
    assign vga.oVGA_VS    = v_sync;
    assign vga.oLineTick  = line_tick_reg;
    assign vga.oFrameTick = frame_tick_reg;

`ifdef VGA_TIMING_TEST_PATTERN_EN
    localparam int BAR_W = (H_ACTIVE >= 8) ? (H_ACTIVE / 8) : 1;

    rgb_t pattern_reg;
    logic next_active;

    assign next_active = in_span(h_next, 0, H_ACTIVE) && in_span(v_next, 0, V_ACTIVE);

    // Colour bars registered from the look-ahead coordinate, aligned with oX.
    always_ff @(posedge iClock) begin
        if (!iReset_n) begin
            pattern_reg <= '0;
        end else if (pe) begin
            pattern_reg <= next_active ? bar_colour(h_next, BAR_W) : '0;
        end
    end

    assign vga.oTestR = pattern_reg.r;
    assign vga.oTestG = pattern_reg.g;
    assign vga.oTestB = pattern_reg.b;
`else
    assign vga.oTestR = 4'b0000;
    assign vga.oTestG = 4'b0000;
    assign vga.oTestB = 4'b0000;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen using a reduced raster so whole
// frames fit in a short run. The reference model derives every output from
// the number of clock edges since reset release with plain arithmetic.
// Honours VGA_TIMING_TEST_PATTERN_EN for the colour outputs.
module tb_vga_timing_gen;

    localparam int HA = 16;
    localparam int HF = 2;
    localparam int HS = 3;
    localparam int HB = 4;
    localparam int VA = 8;
    localparam int VF = 1;
    localparam int VS = 2;
    localparam int VB = 2;
    localparam int PD = 2;
    localparam bit POL = 1'b0;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME_CYC = HT * VT * PD;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    vga_timing_gen_if vga ();

    vga_timing_gen #(
        .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
        .PIX_DIV  (PD), .SYNC_POL (POL)
    ) dut (
        .iClock   (clk),
        .iReset_n (rst_n),
        .vga      (vga)
    );

    int compared = 0;
    int mismatched = 0;

    // Model state: edges since the last edge that sampled reset low.
    int n = 0;
    int cyc = 0;

    // Measurement state for periods, widths and active-pixel counts.
    int lt_last = 0, ft_last = 0, act_cnt = 0, hs_run = 0, vs_run = 0;
    bit lt_valid = 0, ft_valid = 0;

    task automatic check(input string tag, input int got, input int exp);
        compared++;
        if (got != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d (t=%0t n=%0d)", tag, got, exp, $time, n);
        end
    endtask

    function automatic int model_x();
        return (n / PD) % HT;
    endfunction

    function automatic int model_y();
        return ((n / PD) / HT) % VT;
    endfunction

    task automatic compare_outputs(input bit reset_edge);
        int  x, y, exp_r, exp_g, exp_b, idx;
        bit  fresh, pix, act, hsync, vsync;
        x     = model_x();
        y     = model_y();
        fresh = ((n / PD) == 0);
        pix   = (n > 0) && ((n % PD) == 0);
        act   = !fresh && (x < HA) && (y < VA);
        hsync = (!fresh && x >= HA + HF && x < HA + HF + HS) ? POL : !POL;
        vsync = (!fresh && y >= VA + VF && y < VA + VF + VS) ? POL : !POL;
        exp_r = 0; exp_g = 0; exp_b = 0;
`ifdef VGA_TIMING_TEST_PATTERN_EN
        if (act) begin
            idx   = x / (HA / 8);
            exp_r = ((idx >> 2) & 1) != 0 ? 15 : 0;
            exp_g = ((idx >> 1) & 1) != 0 ? 15 : 0;
            exp_b = (idx & 1) != 0 ? 15 : 0;
        end
`else
        idx = 0;
`endif
        check("x",          int'(vga.oX),         x);
        check("y",          int'(vga.oY),         y);
        check("pix_en",     int'(vga.oPixEn),     int'(pix));
        check("active",     int'(vga.oActive),    int'(act));
        check("hsync",      int'(vga.oVGA_HS),    int'(hsync));
        check("vsync",      int'(vga.oVGA_VS),    int'(vsync));
        check("line_tick",  int'(vga.oLineTick),  int'(pix && x == 0));
        check("frame_tick", int'(vga.oFrameTick), int'(pix && x == 0 && y == 0));
        check("test_r",     int'(vga.oTestR),     exp_r + idx * 0);
        check("test_g",     int'(vga.oTestG),     exp_g);
        check("test_b",     int'(vga.oTestB),     exp_b);

        if (reset_edge) begin
            lt_valid = 0; ft_valid = 0; act_cnt = 0; hs_run = 0; vs_run = 0;
        end else begin
            if (vga.oLineTick) begin
                if (lt_valid) check("line_period", cyc - lt_last, HT * PD);
                lt_last = cyc; lt_valid = 1;
            end
            if (vga.oFrameTick) begin
                if (ft_valid) begin
                    check("frame_period", cyc - ft_last, FRAME_CYC);
                    check("active_pixels", act_cnt, HA * VA);
                end
                ft_last = cyc; ft_valid = 1; act_cnt = 0;
            end
            if (vga.oPixEn && vga.oActive) act_cnt++;
            if (vga.oVGA_HS == POL) hs_run++;
            else begin
                if (hs_run > 0) check("hs_width", hs_run, HS * PD);
                hs_run = 0;
            end
            if (vga.oVGA_VS == POL) vs_run++;
            else begin
                if (vs_run > 0) check("vs_width", vs_run, VS * HT * PD);
                vs_run = 0;
            end
        end
    endtask

    // One clock: advance the model with the reset value seen at the edge,
    // then compare just after the edge.
    task automatic step();
        bit reset_edge;
        @(posedge clk);
        reset_edge = !rst_n;
        if (reset_edge) n = 0;
        else n++;
        cyc++;
        #1;
        compare_outputs(reset_edge);
    endtask

    initial begin
        bit found;
        int r, c;

        // Reset held for five cycles, then three clean frames.
        rst_n = 1'b0;
        repeat (5) step();
        rst_n = 1'b1;
        repeat (3 * FRAME_CYC + 10) step();
        $display("txn power-on: reset 5 cycles, ran %0d cycles, at x=%0d y=%0d",
                 3 * FRAME_CYC + 10, model_x(), model_y());

        // Single-cycle reset at a chosen mid-frame position.
        found = 0;
        for (int i = 0; i < FRAME_CYC && !found; i++) begin
            step();
            if (model_x() == 7 && model_y() == 3 && (n % PD) == 0) found = 1;
        end
        check("reach_mid_frame", int'(found), 1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        repeat (FRAME_CYC + 20) step();
        $display("txn mid-frame reset at x=7 y=3, then ran %0d cycles", FRAME_CYC + 20);

        // Random reset pulses at random points in the raster.
        for (int seg = 0; seg < 20; seg++) begin
            r = $urandom_range(1, 3);
            c = $urandom_range(1, 2 * FRAME_CYC);
            rst_n = 1'b0;
            repeat (r) step();
            rst_n = 1'b1;
            repeat (c) step();
            $display("txn seg %0d: reset %0d cycles, ran %0d cycles, at x=%0d y=%0d",
                     seg, r, c, model_x(), model_y());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
